serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
//
// PURPOSE
//  Parallel-in, serial-out frame transmitter built from clocked flip-flops.
//  - Accepts a DATA_W-bit word over a valid/ready handshake.
//  - Drives it onto a single-wire line as start bit (0), data LSB-first, stop bit (1).
//  - Serves as the sending end of the team's serial link; the matching deserialiser
//    samples tx at the same bit period.
//
// PARAMETERS
//  DATA_W        8   data bits per frame (>= 1)
//  CLKS_PER_BIT  4   clk cycles each bit is held on tx (>= 1)
//
// PORTS
//  clk      in   1        single clock; all state updates on rising edge
//  reset    in   1        synchronous, active-high reset
//  data_in  in   DATA_W   word to send; sampled only on accept
//  valid    in   1        producer has a word on data_in
//  ready    out  1        transmitter idle, can accept this cycle
//  tx       out  1        serial line, idles high, registered output
//  busy     out  1        high while a frame is on the line (START..STOP)
//  done     out  1        one-cycle pulse: frame fully transmitted
//
// BEHAVIOUR
//  - Reset (sync, takes effect at the edge where reset=1):
//    - state=IDLE, tx=1, ready=1, busy=0, done=0.
//    - Shift register and counters cleared.
//  - States: IDLE -> START -> DATA -> STOP -> IDLE.
//  - Accept: valid && ready at a rising edge.
//    - Loads data_in into the shift register.
//    - Next cycle: state=START, tx=0, ready=0, busy=1.
//    - data_in/valid are ignored while not IDLE.
//  - ready = (state==IDLE). busy = !ready.
//  - Bit timing: a bit counter runs 0..CLKS_PER_BIT-1; each bit holds tx for
//    exactly CLKS_PER_BIT cycles.
//  - START: after CLKS_PER_BIT cycles go to DATA with tx = bit 0.
//  - DATA: after each bit period, shift right and present the next bit.
//    - Index counter 0..DATA_W-1.
//    - After bit DATA_W-1 completes, go to STOP with tx=1.
//  - STOP: after CLKS_PER_BIT cycles go to IDLE.
//    - done=1 for the first IDLE cycle only; tx stays 1.
//  - Back-to-back: a word may be accepted in the done cycle.
//    - Its start bit begins the next cycle.
//    - Minimum frame-to-frame period = (DATA_W+2)*CLKS_PER_BIT + 1 cycles.
//  - CLKS_PER_BIT=1: one bit per cycle, same state sequence.
//  - Reset mid-frame: next edge forces IDLE/tx=1; no done pulse; partial frame
//    is abandoned (never resumed).
//  - reset and valid both high: reset wins; the word is not accepted.
//  - Counter widths: $clog2 of the max count, minimum 1 bit; no wrap beyond
//    terminal values.
//
// STRUCTURE
//  - Shared package/include (serial_pkg):
//    - state encoding localparams (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
//    - START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
//  - Sub-module bit_timer (param CLKS_PER_BIT):
//    - counts while enabled;
//    - outputs a one-cycle tick on the last cycle of each bit period;
//    - sync reset and clear on enable low.
//  - Top: FSM, shift register, bit-index counter, tx register.
//
// TESTING  (DATA_W=8, CLKS_PER_BIT=4 unless noted)
//  - Reset: hold reset 2 cycles with valid=1 ->
//    tx=1, ready=1, busy=0, done=0; no frame starts.
//  - Accept 8'hA5 at edge k ->
//    tx = 0,1,0,1,0,0,1,0,1,1 each held 4 cycles from k+1;
//    done high only at cycle k+41; ready=1 from k+41.
//  - valid held high with 8'h0F then 8'hF0 ->
//    second start bit begins the cycle after done; frames 41 cycles apart;
//    data_in changes mid-frame do not alter tx.
//  - Reset asserted during DATA bit 3 ->
//    next cycle tx=1, IDLE, ready=1, no done;
//    a new word accepted afterwards sends cleanly.
//  - CLKS_PER_BIT=1, send 8'h01 ->
//    tx = 0,1,0,0,0,0,0,0,0,1 on consecutive cycles; done 11 cycles after accept.
//  - valid low throughout -> tx stays 1, done never pulses.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared constants for the serial link: FSM encoding, line levels, counter sizing.
package serial_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int width_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Word handshake into the serial transmitter: producer is master, transmitter is slave.
interface serial_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              valid;
    logic              ready;

    modport master (output data_in, output valid, input ready);
    modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, tick on the last cycle.
// Latency: tick is combinational from the count; first tick CLKS_PER_BIT cycles after enable rises.
// Backpressure: none; disabling clears the count so every enable starts a fresh period.
module bit_timer
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int               CNT_W = width_for(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in serial-out frame transmitter: start bit, DATA_W bits LSB-first, stop bit.
// Latency: start bit on tx the cycle after accept; done pulses (DATA_W+2)*CLKS_PER_BIT+1 cycles after accept.
// Backpressure: ready only while idle; valid/data_in are ignored for the whole frame.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    serial_frame_tx_if.slave   up,
    output logic               tx,
    output logic               busy,
    output logic               done
);

    localparam int               IDX_W    = width_for(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    logic [1:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;
    logic              bit_tick;
    logic              accept;

    assign up.ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = up.valid && up.ready;

    // Timer idles (and clears) between frames, so each frame starts on a full bit period.
    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .en    (busy),
        .tick  (bit_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tx    <= IDLE_LEVEL;
            done  <= 1'b0;
            shreg <= '0;
            idx   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg <= up.data_in;
                        tx    <= START_BIT;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                        idx   <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (idx == LAST_IDX) begin
                            tx    <= STOP_BIT;
                            state <= STOP;
                        end else begin
                            tx    <= shreg[0];
                            shreg <= shreg >> 1;
                            idx   <= idx + IDX_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        tx    <= IDLE_LEVEL;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Drives two transmitters (4 and 1 clocks per bit) from shared stimulus against a frame-timing model.
module tb_serial_frame_tx;

    localparam int W  = 8;
    localparam int NH = 4096;

    logic         clk = 1'b0;
    logic         rst;
    logic         vld;
    logic [W-1:0] din;
    logic         tx_a, busy_a, done_a;
    logic         tx_b, busy_b, done_b;

    always #5 clk = ~clk;

    serial_frame_tx_if #(.DATA_W(W)) bus_a ();
    serial_frame_tx_if #(.DATA_W(W)) bus_b ();

    assign bus_a.data_in = din;
    assign bus_a.valid   = vld;
    assign bus_b.data_in = din;
    assign bus_b.valid   = vld;

    serial_frame_tx #(.DATA_W(W), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .reset(rst), .up(bus_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    serial_frame_tx #(.DATA_W(W), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .reset(rst), .up(bus_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Model: a frame is fully described by the cycle its start bit appears and its word.
    bit           act   [2];
    int           start [2];
    logic [W-1:0] word  [2];
    logic         hist_tx   [2][NH];
    logic         hist_done [2][NH];

    function automatic int cpb_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int flen(input int d);
        return (W + 2) * cpb_of(d);
    endfunction

    function automatic bit exp_busy(input int d, input int t);
        return act[d] && (t - start[d] < flen(d));
    endfunction

    function automatic bit exp_done(input int d, input int t);
        return act[d] && (t - start[d] == flen(d));
    endfunction

    function automatic logic exp_line(input int d, input int t);
        int p;
        if (!exp_busy(d, t)) return 1'b1;
        p = (t - start[d]) / cpb_of(d);
        if (p == 0) return 1'b0;
        if (p <= W) return word[d][p-1];
        return 1'b1;
    endfunction

    function automatic logic [W-1:0] decode(input int d, input int s);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = hist_tx[d][s + cpb_of(d) * (i + 1)];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        int t;
        @(posedge clk);
        t = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                act[d] = 1'b0;
            end else if (!exp_busy(d, t - 1) && vld) begin
                act[d]   = 1'b1;
                start[d] = t;
                word[d]  = din;
            end
        end
        cyc = t;
        #1;
        if (cyc < NH) begin
            hist_tx[0][cyc]   = tx_a;
            hist_tx[1][cyc]   = tx_b;
            hist_done[0][cyc] = done_a;
            hist_done[1][cyc] = done_b;
        end
        if (chk_en) begin
            check("tx_a",   tx_a,        exp_line(0, cyc));
            check("busy_a", busy_a,      exp_busy(0, cyc));
            check("rdy_a",  bus_a.ready, !exp_busy(0, cyc));
            check("done_a", done_a,      exp_done(0, cyc));
            check("tx_b",   tx_b,        exp_line(1, cyc));
            check("busy_b", busy_b,      exp_busy(1, cyc));
            check("rdy_b",  bus_b.ready, !exp_busy(1, cyc));
            check("done_b", done_b,      exp_done(1, cyc));
        end
    endtask

    initial begin
        int s, s1, s2, n;
        logic [9:0] pat;

        act[0] = 1'b0;
        act[1] = 1'b0;

        // Reset held two cycles with valid high: nothing may start.
        rst = 1'b1;
        vld = 1'b1;
        din = W'($urandom);
        step();
        chk_en = 1'b1;
        step();
        check("rst_tx_a",   tx_a, 1);
        check("rst_rdy_a",  bus_a.ready, 1);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        rst = 1'b0;
        vld = 1'b0;
        repeat (3) step();
        check("post_rst_tx_a", tx_a, 1);

        // Single frame 8'hA5.
        vld = 1'b1;
        din = 8'hA5;
        step();
        s = cyc;
        vld = 1'b0;
        repeat (44) step();
        pat = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 4; j++) check("a5_wave", hist_tx[0][s + 4*i + j], pat[i]);
        end
        check("a5_done_early", hist_done[0][s + 39], 0);
        check("a5_done",       hist_done[0][s + 40], 1);
        check("a5_done_late",  hist_done[0][s + 41], 0);
        check("a5_done_b",     hist_done[1][s + 10], 1);

        // Valid held high: 0F then F0 back to back, data_in churning mid-frame.
        vld = 1'b1;
        din = 8'h0F;
        step();
        s1 = cyc;
        for (int j = 1; j <= 41; j++) begin
            din = (j == 41) ? 8'hF0 : W'($urandom);
            step();
        end
        s2 = cyc;
        vld = 1'b0;
        repeat (45) step();
        check("b2b_done1",   hist_done[0][s1 + 40], 1);
        check("b2b_stop",    hist_tx[0][s1 + 40], 1);
        check("b2b_start2",  hist_tx[0][s1 + 41], 0);
        check("b2b_word1",   decode(0, s1), 8'h0F);
        check("b2b_word2",   decode(0, s2), 8'hF0);
        check("b2b_done2",   hist_done[0][s2 + 40], 1);

        // Reset during data bit 3, then a clean frame.
        vld = 1'b1;
        din = W'($urandom);
        step();
        s = cyc;
        vld = 1'b0;
        while (cyc < s + 17) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_tx",   tx_a, 1);
        check("midrst_rdy",  bus_a.ready, 1);
        check("midrst_done", done_a, 0);
        n = 0;
        repeat (50) begin
            step();
            if (done_a) n++;
        end
        check("midrst_nodone", n, 0);
        vld = 1'b1;
        din = 8'h3C;
        step();
        s = cyc;
        vld = 1'b0;
        repeat (44) step();
        check("midrst_word", decode(0, s), 8'h3C);
        check("midrst_done2", hist_done[0][s + 40], 1);

        // One clock per bit: 8'h01.
        vld = 1'b1;
        din = 8'h01;
        step();
        s = cyc;
        vld = 1'b0;
        repeat (44) step();
        pat = {1'b1, 8'h01, 1'b0};
        for (int i = 0; i < 10; i++) check("b01_wave", hist_tx[1][s + i], pat[i]);
        check("b01_done", hist_done[1][s + 10], 1);

        // Valid low: line idles, no done.
        n = 0;
        repeat (100) begin
            step();
            if (done_a || done_b || !tx_a || !tx_b) n++;
        end
        check("quiet", n, 0);

        // Random traffic with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            vld = ($urandom_range(0, 3) == 0);
            din = W'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        vld = 1'b0;
        repeat (50) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
